// File: rtl/rim_boot_sequencer_pkg.sv
// Shared types and constants for the RIM loader boot sequencer.
// The state enum is also what checkers bind to when probing the FSM.
package rim_boot_sequencer_pkg;

    localparam int          RIM_WIDTH = 12;
    localparam logic [11:0] RIM_BASE  = 12'o7756;
    localparam int          RIM_WORDS = 16;
    localparam logic [11:0] RIM_START = 12'o7756;

    typedef logic [RIM_WIDTH-1:0] rim_word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_LOADPC  = 3'd5,
        ST_RELEASE = 3'd6
    } boot_state_t;

    // RAM address of a loader word; wraps naturally at the 12-bit boundary.
    function automatic rim_word_t word_addr(input rim_word_t base, input logic [3:0] idx);
        return base + rim_word_t'(idx);
    endfunction

endpackage

// File: rtl/boot_timeout_counter.sv
// Halt-acknowledge timeout counter shared by front-panel sequencers.
// hit is asserted in the cycle whose increment would reach LIMIT; LIMIT=0 never hits.
module boot_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int CW    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign hit = inc && (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/rim_boot_sequencer.sv
// Boot sequencer: halts the CPU, copies the RIM loader from the ROM table into
// core RAM one strobed word at a time, loads the PC and hands the bus back.
module rim_boot_sequencer
    import rim_boot_sequencer_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR    = RIM_BASE,
    parameter int          WORDS        = RIM_WORDS,
    parameter logic [11:0] START_PC     = RIM_START,
    parameter int          WE_CYCLES    = 1,
    parameter int          HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  rom_index,
    input  logic [11:0] rom_data,
    output logic        cpu_halt_req,
    input  logic        cpu_halted,
    output logic        ram_sel,
    output logic [11:0] ram_addr,
    output logic [11:0] ram_data,
    output logic        ram_we,
    output logic        pc_load,
    output logic [11:0] pc_value,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0]     LAST_IDX = 4'(WORDS - 1);
    localparam int             WCW      = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [WCW-1:0] WE_LAST  = WCW'(WE_CYCLES - 1);
    localparam int             TCW      = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;

    boot_state_t    state;
    logic [3:0]     index;
    logic           last_word;
    logic [WCW-1:0] we_cnt;
    logic           to_hit;

    boot_timeout_counter #(
        .LIMIT (HALT_TIMEOUT),
        .CW    (TCW)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .inc   ((state == ST_HALT) && !cpu_halted),
        .hit   (to_hit)
    );

    assign rom_index = index;
    assign pc_value  = START_PC;

    // Outputs are registered alongside the state transition that enters each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            index        <= '0;
            last_word    <= 1'b0;
            we_cnt       <= '0;
            cpu_halt_req <= 1'b0;
            ram_sel      <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
            ram_we       <= 1'b0;
            pc_load      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cpu_halt_req <= 1'b0;
                    if (start) begin
                        state        <= ST_HALT;
                        index        <= '0;
                        last_word    <= 1'b0;
                        busy         <= 1'b1;
                        cpu_halt_req <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (cpu_halted) begin
                        state    <= ST_SETUP;
                        ram_sel  <= 1'b1;
                        ram_addr <= word_addr(BASE_ADDR, index);
                        ram_data <= rom_data;
                    end else if (to_hit) begin
                        // halt request is withdrawn on the following cycle, from IDLE
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state  <= ST_STROBE;
                    ram_we <= 1'b1;
                    we_cnt <= '0;
                end
                ST_STROBE: begin
                    if (we_cnt == WE_LAST) begin
                        // advance the ROM index now so the next word is ready by SETUP
                        state     <= ST_HOLD;
                        ram_we    <= 1'b0;
                        last_word <= (index == LAST_IDX);
                        if (index != LAST_IDX) begin
                            index <= index + 4'd1;
                        end
                    end else begin
                        we_cnt <= we_cnt + WCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (last_word) begin
                        state    <= ST_LOADPC;
                        pc_load  <= 1'b1;
                        ram_addr <= '0;
                        ram_data <= '0;
                    end else begin
                        state    <= ST_SETUP;
                        ram_addr <= word_addr(BASE_ADDR, index);
                        ram_data <= rom_data;
                    end
                end
                ST_LOADPC: begin
                    state        <= ST_RELEASE;
                    ram_sel      <= 1'b0;
                    cpu_halt_req <= 1'b0;
                    done         <= 1'b1;
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    cpu_halt_req <= 1'b0;
                    ram_sel      <= 1'b0;
                    ram_we       <= 1'b0;
                    ram_addr     <= '0;
                    ram_data     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rim_boot_sequencer.sv
// Bench for rim_boot_sequencer: a default instance and a WE_CYCLES=3 / short-timeout /
// wrapping instance, checked against a RAM-write list and timing computed from the rules.
module tb_rim_boot_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] rim_rom [16] = '{12'o6032, 12'o6031, 12'o5357, 12'o6036,
                                  12'o7106, 12'o7006, 12'o7510, 12'o5357,
                                  12'o7006, 12'o6031, 12'o5367, 12'o6034,
                                  12'o7420, 12'o3776, 12'o3376, 12'o5356};

    // instance a: defaults
    logic a_start = 1'b0, a_halted = 1'b0;
    logic [3:0] a_rom_index;
    logic [11:0] a_rom_data, a_addr, a_data, a_pc_value;
    logic a_halt_req, a_sel, a_we, a_pc_load, a_busy, a_done, a_err;
    assign a_rom_data = rim_rom[a_rom_index];

    rim_boot_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .rom_index(a_rom_index),
        .rom_data(a_rom_data), .cpu_halt_req(a_halt_req), .cpu_halted(a_halted),
        .ram_sel(a_sel), .ram_addr(a_addr), .ram_data(a_data), .ram_we(a_we),
        .pc_load(a_pc_load), .pc_value(a_pc_value), .busy(a_busy), .done(a_done), .err(a_err)
    );

    // instance b: wide strobe, short timeout, image wrapping past 7777
    logic b_start = 1'b0, b_halted = 1'b0;
    logic [3:0] b_rom_index;
    logic [11:0] b_rom_data, b_addr, b_data, b_pc_value;
    logic b_halt_req, b_sel, b_we, b_pc_load, b_busy, b_done, b_err;
    assign b_rom_data = rim_rom[b_rom_index];

    rim_boot_sequencer #(
        .BASE_ADDR(12'o7770), .WORDS(12), .START_PC(12'o0200), .WE_CYCLES(3), .HALT_TIMEOUT(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .rom_index(b_rom_index),
        .rom_data(b_rom_data), .cpu_halt_req(b_halt_req), .cpu_halted(b_halted),
        .ram_sel(b_sel), .ram_addr(b_addr), .ram_data(b_data), .ram_we(b_we),
        .pc_load(b_pc_load), .pc_value(b_pc_value), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // monitor, watching whichever instance is under test
    logic mon_sel = 1'b0;
    logic m_we, m_sel, m_pc_load, m_done, m_err, m_busy;
    logic [11:0] m_addr, m_data, m_pc_value;
    assign m_we       = mon_sel ? b_we : a_we;
    assign m_sel      = mon_sel ? b_sel : a_sel;
    assign m_addr     = mon_sel ? b_addr : a_addr;
    assign m_data     = mon_sel ? b_data : a_data;
    assign m_pc_load  = mon_sel ? b_pc_load : a_pc_load;
    assign m_pc_value = mon_sel ? b_pc_value : a_pc_value;
    assign m_done     = mon_sel ? b_done : a_done;
    assign m_err      = mon_sel ? b_err : a_err;
    assign m_busy     = mon_sel ? b_busy : a_busy;

    logic [23:0] wr_q[$];
    logic [23:0] exp_q[$];
    logic [11:0] pcv_q[$];
    int we_len_q[$], done_q[$], pc_q[$], err_q[$];
    int unstable, leak, first_sel, first_we, we_len;
    logic we_prev = 1'b0, sel_prev = 1'b0;
    logic [11:0] addr_prev = '0, data_prev = '0;

    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (!m_sel && (m_addr != 12'd0 || m_data != 12'd0)) leak++;
        if (m_we && !m_sel) unstable++;
        if (m_sel && first_sel < 0) first_sel = cyc;
        if (m_we && !we_prev) begin
            wr_q.push_back({m_addr, m_data});
            we_len = 1;
            if (first_we < 0) first_we = cyc;
            if (!sel_prev || m_addr != addr_prev || m_data != data_prev) unstable++;
        end else if (m_we) begin
            we_len++;
            if (m_addr != addr_prev || m_data != data_prev) unstable++;
        end else if (we_prev) begin
            we_len_q.push_back(we_len);
            if (!m_sel || m_addr != addr_prev || m_data != data_prev) unstable++;
        end
        if (m_done) done_q.push_back(cyc);
        if (m_err) err_q.push_back(cyc);
        if (m_pc_load) begin
            pc_q.push_back(cyc);
            pcv_q.push_back(m_pc_value);
        end
        we_prev = m_we;
        sel_prev = m_sel;
        addr_prev = m_addr;
        data_prev = m_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear(input bit inst);
        mon_sel = inst;
        wr_q.delete(); we_len_q.delete(); done_q.delete(); pc_q.delete();
        pcv_q.delete(); err_q.delete();
        unstable = 0; leak = 0; first_sel = -1; first_we = -1; we_len = 0;
    endtask

    task automatic set_start(input bit inst, input logic v);
        if (inst) b_start = v; else a_start = v;
    endtask

    task automatic set_halted(input bit inst, input logic v);
        if (inst) b_halted = v; else a_halted = v;
    endtask

    // cpu_halted rises d cycles after start (0 = already high); optional drop mid-load
    task automatic run_boot(input bit inst, input int d, input bit drop, input int repulse_at,
                            input int budget, output int s);
        mon_clear(inst);
        set_halted(inst, d == 0);
        s = cyc;
        set_start(inst, 1'b1);
        for (int k = 1; k <= budget; k++) begin
            tick();
            set_start(inst, (repulse_at >= 0 && wr_q.size() == repulse_at) ? 1'b1 : 1'b0);
            if (k == d) set_halted(inst, 1'b1);
            if (drop && k == d + 6) set_halted(inst, 1'b0);
        end
        set_halted(inst, 1'b0);
    endtask

    // Expected RAM image and timing come from the boot rules: one write per word at
    // base+i (mod 4096), WE+2 clocks per word, then LOADPC and RELEASE.
    task automatic check_boot(input string tag, input int s, input int h, input logic [11:0] base,
                              input int words, input int we_c, input logic [11:0] pc);
        int t_done;
        int bad;
        exp_q.delete();
        for (int i = 0; i < words; i++) exp_q.push_back({base + 12'(i), rim_rom[i]});
        t_done = s + h + words * (we_c + 2) + 2;
        check({tag, " write count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s write %0d", tag, i), wr_q[i], exp_q[i]);
        bad = 0;
        foreach (we_len_q[i]) if (we_len_q[i] != we_c) bad++;
        check({tag, " we pulses"}, we_len_q.size(), words);
        check({tag, " we width"}, bad, 0);
        check({tag, " addr/data stable"}, unstable, 0);
        check({tag, " bus zero when unselected"}, leak, 0);
        check({tag, " first ram_sel"}, first_sel, s + h + 1);
        check({tag, " first ram_we"}, first_we, s + h + 2);
        check({tag, " done count"}, done_q.size(), 1);
        check({tag, " done time"}, (done_q.size() > 0) ? done_q[0] : -1, t_done);
        check({tag, " pc_load count"}, pc_q.size(), 1);
        check({tag, " pc_load time"}, (pc_q.size() > 0) ? pc_q[0] : -1, t_done - 1);
        check({tag, " pc_value"}, (pcv_q.size() > 0) ? pcv_q[0] : 12'hfff, pc);
        check({tag, " err count"}, err_q.size(), 0);
        check({tag, " idle after"}, m_busy, 1'b0);
    endtask

    initial begin
        int s;
        int d;
        bit hit;

        // reset values
        tick(); tick();
        check("reset a controls", {a_halt_req, a_sel, a_we, a_pc_load, a_busy, a_done, a_err}, 7'd0);
        check("reset a bus", {a_addr, a_data}, 24'd0);
        check("reset a pc_value", a_pc_value, 12'o7756);
        check("reset a rom_index", a_rom_index, 4'd0);
        check("reset b controls", {b_halt_req, b_sel, b_we, b_pc_load, b_busy, b_done, b_err}, 7'd0);
        check("reset b pc_value", b_pc_value, 12'o0200);
        rst_n = 1'b1;
        tick();

        // normal boot, CPU already halted: done 51 clocks after start
        run_boot(1'b0, 0, 1'b0, -1, 60, s);
        check_boot("normal", s, 1, 12'o7756, 16, 1, 12'o7756);
        check("normal latency", (done_q.size() > 0) ? done_q[0] - s : -1, 51);

        // halt handshake after 10 clocks, then randomized delays with a dropped ack
        run_boot(1'b0, 10, 1'b0, -1, 75, s);
        check_boot("halt10", s, 10, 12'o7756, 16, 1, 12'o7756);
        for (int r = 0; r < 3; r++) begin
            d = $urandom_range(1, 12);
            run_boot(1'b0, d, (r % 2) == 0, -1, d + 60, s);
            check_boot($sformatf("rand%0d d=%0d", r, d), s, d, 12'o7756, 16, 1, 12'o7756);
        end

        // start re-pulsed while busy during word 3
        run_boot(1'b0, 0, 1'b0, 3, 70, s);
        check_boot("start busy", s, 1, 12'o7756, 16, 1, 12'o7756);

        // reset during the STROBE of word 5
        mon_clear(1'b0);
        a_halted = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (wr_q.size() == 6 && a_we) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("midload reached word5 strobe", hit, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midload async drop", {a_we, a_sel, a_halt_req, a_busy}, 4'd0);
        check("midload pc_value", a_pc_value, 12'o7756);
        tick();
        rst_n = 1'b1;
        a_halted = 1'b0;
        tick();
        run_boot(1'b0, 2, 1'b0, -1, 65, s);
        check_boot("after reset", s, 2, 12'o7756, 16, 1, 12'o7756);

        // halt timeout on instance b
        mon_clear(1'b1);
        b_halted = 1'b0;
        s = cyc;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("timeout err count", err_q.size(), 1);
        check("timeout err time", (err_q.size() > 0) ? err_q[0] : -1, s + 9);
        check("timeout no writes", wr_q.size(), 0);
        check("timeout no pc_load", pc_q.size(), 0);
        check("timeout no done", done_q.size(), 0);
        check("timeout no ram_sel", first_sel, -1);
        check("timeout released", {b_busy, b_halt_req}, 2'd0);

        // WE_CYCLES=3 with address wrap, fixed and random halt delay
        run_boot(1'b1, 3, 1'b0, -1, 80, s);
        check_boot("we3 wrap", s, 3, 12'o7770, 12, 3, 12'o0200);
        d = $urandom_range(1, 8);
        run_boot(1'b1, d, 1'b1, -1, d + 75, s);
        check_boot($sformatf("we3 rand d=%0d", d), s, d, 12'o7770, 12, 3, 12'o0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
